// File: rtl/param_stack.sv
// Parametrised LIFO stack with registered TOS/NOS, occupancy, status and sticky error flags.
// Optional top-two exchange is enabled by defining STACK_SWAP_EN.
module param_stack #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         swap,
    input  logic                         clr_err,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             tos,
    output logic [WIDTH-1:0]             nos,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned AW = $clog2(DEPTH);

`ifdef STACK_SWAP_EN
    localparam bit SWAP_EN = 1'b1;
`else
    localparam bit SWAP_EN = 1'b0;
`endif

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] tos_q, tos_d;
    logic [WIDTH-1:0] nos_q, nos_d;
    logic             empty_q, empty_d;
    logic             full_q, full_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic             has_one;
    logic             has_two;
    logic             is_full;
    logic             ovf_set;
    logic             unf_set;
    logic [WIDTH-1:0] tmp;

    // Decode the request, update storage/occupancy, then derive the registered views from the new state.
    always_comb begin
        mem_d   = mem_q;
        count_d = count_q;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        tmp     = '0;
        tos_d   = '0;
        nos_d   = '0;
        has_one = (count_q != '0);
        has_two = (count_q >= CW'(2));
        is_full = (count_q == CW'(DEPTH));

        if (push && pop) begin
            if (has_one) begin
                mem_d[AW'(count_q - CW'(1))] = din;
            end else begin
                mem_d[AW'(0)] = din;
                count_d       = CW'(1);
            end
        end else if (push) begin
            if (is_full) begin
                ovf_set = 1'b1;
            end else begin
                mem_d[AW'(count_q)] = din;
                count_d             = count_q + CW'(1);
            end
        end else if (pop) begin
            if (has_one) begin
                count_d = count_q - CW'(1);
            end else begin
                unf_set = 1'b1;
            end
        end else if (SWAP_EN && swap) begin
            if (has_two) begin
                tmp                          = mem_q[AW'(count_q - CW'(1))];
                mem_d[AW'(count_q - CW'(1))] = mem_q[AW'(count_q - CW'(2))];
                mem_d[AW'(count_q - CW'(2))] = tmp;
            end else begin
                unf_set = 1'b1;
            end
        end

        if (count_d != '0) begin
            tos_d = mem_d[AW'(count_d - CW'(1))];
        end
        if (count_d >= CW'(2)) begin
            nos_d = mem_d[AW'(count_d - CW'(2))];
        end
        empty_d     = (count_d == '0);
        full_d      = (count_d == CW'(DEPTH));
        // A new error in the same cycle as a clear leaves the flag set.
        overflow_d  = (overflow_q  & ~clr_err) | ovf_set;
        underflow_d = (underflow_q & ~clr_err) | unf_set;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q     <= '0;
            tos_q       <= '0;
            nos_q       <= '0;
            empty_q     <= 1'b1;
            full_q      <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            tos_q       <= tos_d;
            nos_q       <= nos_d;
            empty_q     <= empty_d;
            full_q      <= full_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage needs no reset: entries at or above count are never observed.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign tos       = tos_q;
    assign nos       = nos_q;
    assign count     = count_q;
    assign empty     = empty_q;
    assign full      = full_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_param_stack.sv
// Self-checking bench for param_stack (WIDTH=8, DEPTH=4) against a queue-based LIFO model.
module tb_param_stack;

    localparam int unsigned W = 8;
    localparam int unsigned D = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         push = 1'b0, pop = 1'b0, swap = 1'b0, clr_err = 1'b0;
    logic [W-1:0] din = '0;
    logic [W-1:0] tos, nos;
    logic [2:0]   count;
    logic         empty, full, overflow, underflow;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] mq[$];
    bit           m_ovf = 1'b0;
    bit           m_unf = 1'b0;

    param_stack #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .swap(swap), .clr_err(clr_err),
        .din(din), .tos(tos), .nos(nos), .count(count), .empty(empty), .full(full),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] m_tos();
        return (mq.size() > 0) ? mq[mq.size()-1] : '0;
    endfunction

    function automatic logic [W-1:0] m_nos();
        return (mq.size() > 1) ? mq[mq.size()-2] : '0;
    endfunction

    // Reference LIFO semantics applied at one clock edge.
    task automatic model_step(input bit p, input bit po, input bit s, input bit c, input logic [W-1:0] d);
        bit so, su;
        logic [W-1:0] t;
        so = 0; su = 0;
        if (p && po) begin
            if (mq.size() > 0) mq[mq.size()-1] = d;
            else mq.push_back(d);
        end else if (p) begin
            if (mq.size() == D) so = 1;
            else mq.push_back(d);
        end else if (po) begin
            if (mq.size() > 0) void'(mq.pop_back());
            else su = 1;
        end else if (s) begin
`ifdef STACK_SWAP_EN
            if (mq.size() >= 2) begin
                t = mq[mq.size()-1];
                mq[mq.size()-1] = mq[mq.size()-2];
                mq[mq.size()-2] = t;
            end else su = 1;
`endif
        end
        m_ovf = (m_ovf && !c) || so;
        m_unf = (m_unf && !c) || su;
    endtask

    // One operating edge: drive, update model at the edge, release inputs, sample 1 ns later.
    task automatic cycle(input bit p, input bit po, input bit s, input bit c, input logic [W-1:0] d);
        @(negedge clk);
        push = p; pop = po; swap = s; clr_err = c; din = d;
        @(posedge clk);
        model_step(p, po, s, c, d);
        #1;
        push = 0; pop = 0; swap = 0; clr_err = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
        checks++; if (tos !== 8'h00 || nos !== 8'h00) begin errors++; $display("FAIL reset_tos_nos got %h/%h exp 00/00", tos, nos); end
        checks++; if ({empty, full, overflow, underflow} !== 4'b1000) begin errors++; $display("FAIL reset_flags got %b exp 1000", {empty, full, overflow, underflow}); end
        rst = 1'b0;
        mq.delete(); m_ovf = 0; m_unf = 0;
    endtask

    task automatic test_push();
        cycle(1, 0, 0, 0, 8'h11);
        cycle(1, 0, 0, 0, 8'h22);
        cycle(1, 0, 0, 0, 8'h33);
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL push_count got %0d exp 3", count); end
        checks++; if (tos !== 8'h33) begin errors++; $display("FAIL push_tos got %h exp 33", tos); end
        checks++; if (nos !== 8'h22) begin errors++; $display("FAIL push_nos got %h exp 22", nos); end
        checks++; if ({empty, full} !== 2'b00) begin errors++; $display("FAIL push_status got %b exp 00", {empty, full}); end
    endtask

    task automatic test_overflow();
        cycle(1, 0, 0, 0, 8'h44);
        checks++; if (full !== 1'b1 || tos !== 8'h44) begin errors++; $display("FAIL ovf_fill got full=%b tos=%h exp 1/44", full, tos); end
        cycle(1, 0, 0, 0, 8'h55);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", overflow); end
        checks++; if (tos !== 8'h44 || count !== 3'd4) begin errors++; $display("FAIL ovf_hold got tos=%h count=%0d exp 44/4", tos, count); end
        cycle(0, 0, 0, 1, 8'h00);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b exp 0", overflow); end
    endtask

    task automatic test_pop_drain();
        logic [W-1:0] exp_seq [4];
        exp_seq[0] = 8'h33; exp_seq[1] = 8'h22; exp_seq[2] = 8'h11; exp_seq[3] = 8'h00;
        for (int i = 0; i < 4; i++) begin
            cycle(0, 1, 0, 0, 8'h00);
            checks++; if (tos !== exp_seq[i]) begin errors++; $display("FAIL pop_tos_%0d got %h exp %h", i, tos, exp_seq[i]); end
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL pop_empty got %b exp 1", empty); end
        cycle(0, 1, 0, 0, 8'h00);
        checks++; if (underflow !== 1'b1 || count !== 3'd0) begin errors++; $display("FAIL pop_underflow got unf=%b count=%0d exp 1/0", underflow, count); end
        cycle(0, 0, 0, 1, 8'h00);
    endtask

    task automatic test_replace();
        cycle(1, 0, 0, 0, 8'h11);
        cycle(1, 0, 0, 0, 8'h22);
        cycle(1, 1, 0, 0, 8'hAA);
        checks++; if (tos !== 8'hAA || nos !== 8'h11 || count !== 3'd2) begin errors++; $display("FAIL replace got tos=%h nos=%h count=%0d exp AA/11/2", tos, nos, count); end
        cycle(0, 1, 0, 0, 8'h00);
        cycle(0, 1, 0, 0, 8'h00);
        cycle(1, 1, 0, 0, 8'h5A);
        checks++; if (tos !== 8'h5A || count !== 3'd1) begin errors++; $display("FAIL replace_empty got tos=%h count=%0d exp 5A/1", tos, count); end
        checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL replace_flags got %b exp 00", {overflow, underflow}); end
        cycle(0, 1, 0, 0, 8'h00);
    endtask

    task automatic test_swap();
        cycle(1, 0, 0, 0, 8'h11);
        cycle(1, 0, 0, 0, 8'h22);
        cycle(0, 0, 1, 0, 8'h00);
`ifdef STACK_SWAP_EN
        checks++; if (tos !== 8'h11 || nos !== 8'h22) begin errors++; $display("FAIL swap got %h/%h exp 11/22", tos, nos); end
`else
        checks++; if (tos !== 8'h22 || nos !== 8'h11) begin errors++; $display("FAIL swap_off got %h/%h exp 22/11", tos, nos); end
`endif
        cycle(1, 0, 1, 0, 8'h99);
        checks++; if (tos !== m_tos() || count !== 3'(mq.size())) begin errors++; $display("FAIL swap_with_push got tos=%h count=%0d exp %h/%0d", tos, count, m_tos(), mq.size()); end
        cycle(0, 1, 0, 0, 8'h00);
        cycle(0, 1, 0, 0, 8'h00);
        cycle(0, 0, 1, 0, 8'h00);
`ifdef STACK_SWAP_EN
        checks++; if (underflow !== 1'b1 || count !== 3'd1) begin errors++; $display("FAIL swap_short got unf=%b count=%0d exp 1/1", underflow, count); end
`else
        checks++; if (underflow !== 1'b0 || count !== 3'd1) begin errors++; $display("FAIL swap_short_off got unf=%b count=%0d exp 0/1", underflow, count); end
`endif
        checks++; if (tos !== m_tos()) begin errors++; $display("FAIL swap_short_tos got %h exp %h", tos, m_tos()); end
        cycle(0, 1, 0, 1, 8'h00);
    endtask

    task automatic test_random();
        bit p, po, s, c;
        for (int i = 0; i < 400; i++) begin
            p  = ($urandom % 2) == 1;
            po = ($urandom % 2) == 1;
            s  = ($urandom % 4) == 0;
            c  = ($urandom % 8) == 0;
            cycle(p, po, s, c, W'($urandom));
            checks++; if (tos !== m_tos()) begin errors++; $display("FAIL rnd_tos[%0d] got %h exp %h", i, tos, m_tos()); end
            checks++; if (nos !== m_nos()) begin errors++; $display("FAIL rnd_nos[%0d] got %h exp %h", i, nos, m_nos()); end
            checks++; if (count !== 3'(mq.size())) begin errors++; $display("FAIL rnd_count[%0d] got %0d exp %0d", i, count, mq.size()); end
            checks++; if (empty !== (mq.size() == 0) || full !== (mq.size() == D)) begin errors++; $display("FAIL rnd_status[%0d] got e=%b f=%b exp size %0d", i, empty, full, mq.size()); end
            checks++; if (overflow !== m_ovf || underflow !== m_unf) begin errors++; $display("FAIL rnd_flags[%0d] got o=%b u=%b exp o=%b u=%b", i, overflow, underflow, m_ovf, m_unf); end
        end
    endtask

    task automatic test_async_reset();
        cycle(0, 0, 0, 1, 8'h00);
        while (mq.size() > 0) cycle(0, 1, 0, 0, 8'h00);
        cycle(1, 0, 0, 0, 8'h11);
        cycle(1, 0, 0, 0, 8'h22);
        @(negedge clk);
        rst = 1'b1; push = 1'b1; din = 8'h77;
        #1;
        checks++; if (count !== 3'd0 || tos !== 8'h00 || nos !== 8'h00) begin errors++; $display("FAIL async_rst got count=%0d tos=%h nos=%h exp 0/00/00", count, tos, nos); end
        checks++; if ({empty, full, overflow, underflow} !== 4'b1000) begin errors++; $display("FAIL async_rst_flags got %b exp 1000", {empty, full, overflow, underflow}); end
        @(posedge clk);
        #1;
        checks++; if (count !== 3'd0 || tos !== 8'h00) begin errors++; $display("FAIL rst_push_discard got count=%0d tos=%h exp 0/00", count, tos); end
        @(negedge clk);
        rst = 1'b0; push = 1'b0;
        mq.delete(); m_ovf = 0; m_unf = 0;
        @(posedge clk);
        #1;
        checks++; if (count !== 3'd0 || empty !== 1'b1) begin errors++; $display("FAIL post_rst got count=%0d empty=%b exp 0/1", count, empty); end
    endtask

    initial begin
        test_reset();
        test_push();
        test_overflow();
        test_pop_drain();
        test_replace();
        test_swap();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
